// File: rtl/sphere_pair_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sphere_pair_dispatcher_pkg
// Description : Shared types and constants for the sphere pair dispatcher:
//               FSM state encoding, operand/result bundles, float zero and
//               the default timing parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package sphere_pair_dispatcher_pkg;

    localparam logic [31:0] FLOAT_ZERO             = 32'h0000_0000;
    localparam int unsigned DEFAULT_HOLD_CYCLES    = 2;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 4096;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    // One sphere: centre and radius, all IEEE-754 single, carried as raw bits.
    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [31:0] r;
    } sphere_t;

    // Contact point, contact normal and penetration depth from the engine.
    typedef struct packed {
        logic [31:0] cx;
        logic [31:0] cy;
        logic [31:0] cz;
        logic [31:0] nx;
        logic [31:0] ny;
        logic [31:0] nz;
        logic [31:0] depth;
    } contact_t;

    localparam contact_t CONTACT_ZERO = '{FLOAT_ZERO, FLOAT_ZERO, FLOAT_ZERO,
                                          FLOAT_ZERO, FLOAT_ZERO, FLOAT_ZERO,
                                          FLOAT_ZERO};

endpackage
`default_nettype wire

// File: rtl/sphere_pair_dispatcher_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_watchdog
// Description : RUN-cycle counter with expiry flag. The count is held at zero
//               whenever counting is disabled, so it restarts on every RUN
//               entry. Only compiled when DISPATCH_TIMEOUT_EN is defined.
// Ports       : clk, rst (sync, active-low), i_count_en (high while in RUN),
//               o_expired (high during the TIMEOUT_CYCLES-th RUN cycle)
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef DISPATCH_TIMEOUT_EN
module dispatch_watchdog
    import sphere_pair_dispatcher_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_count_en,
    output logic o_expired
);
    localparam int unsigned        c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!i_count_en) begin
            r_cnt <= '0;
        end else if (!o_expired) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign o_expired = i_count_en && (r_cnt == c_last);

endmodule
`endif
`default_nettype wire

// File: rtl/sphere_pair_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : sphere_pair_dispatcher
// Description : Accepts a sphere pair, holds the collision engine in reset
//               for HOLD_CYCLES, runs it with latched operands, captures the
//               contact result and presents it on an output handshake.
//               Data passes through bit-exact; no arithmetic is performed.
// Ports       : clk, rst (sync, active-low)
//               in_{x,y,z,r}{1,2}, input_stb/input_ack   - request side
//               eng_{x,y,z,r}{1,2}, eng_rst               - engine operands
//               eng_done, eng_ret, eng_{cx..nz,depth}     - engine results
//               out_{cx..nz,depth}, out_ret, out_timeout,
//               output_z_stb/output_z_ack                 - result side
// Options     : DISPATCH_TIMEOUT_EN - RUN watchdog of TIMEOUT_CYCLES cycles
// Revision    : 1.0 - initial release
// ============================================================================
module sphere_pair_dispatcher
    import sphere_pair_dispatcher_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = DEFAULT_HOLD_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_x1,
    input  logic [31:0] in_y1,
    input  logic [31:0] in_z1,
    input  logic [31:0] in_r1,
    input  logic [31:0] in_x2,
    input  logic [31:0] in_y2,
    input  logic [31:0] in_z2,
    input  logic [31:0] in_r2,
    input  logic        input_stb,
    output logic        input_ack,
    output logic [31:0] eng_x1,
    output logic [31:0] eng_y1,
    output logic [31:0] eng_z1,
    output logic [31:0] eng_r1,
    output logic [31:0] eng_x2,
    output logic [31:0] eng_y2,
    output logic [31:0] eng_z2,
    output logic [31:0] eng_r2,
    output logic        eng_rst,
    input  logic        eng_done,
    input  logic        eng_ret,
    input  logic [31:0] eng_cx,
    input  logic [31:0] eng_cy,
    input  logic [31:0] eng_cz,
    input  logic [31:0] eng_nx,
    input  logic [31:0] eng_ny,
    input  logic [31:0] eng_nz,
    input  logic [31:0] eng_depth,
    output logic [31:0] out_cx,
    output logic [31:0] out_cy,
    output logic [31:0] out_cz,
    output logic [31:0] out_nx,
    output logic [31:0] out_ny,
    output logic [31:0] out_nz,
    output logic [31:0] out_depth,
    output logic        out_ret,
    output logic        out_timeout,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    // HOLD_CYCLES must be at least 1.
    localparam int unsigned         c_hold_w    = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_hold_w-1:0] r_hold_cnt;
    sphere_t             r_s1;
    sphere_t             r_s2;
    contact_t            r_contact;
    logic                r_ret;
    logic                r_out_stb;
    logic                w_in_run;
    logic                w_expired;

    assign w_in_run = (r_state == ST_RUN);

`ifdef DISPATCH_TIMEOUT_EN
    logic r_timeout;

    dispatch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .i_count_en (w_in_run),
        .o_expired  (w_expired)
    );

    // eng_done takes priority over a simultaneous expiry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_timeout <= 1'b0;
        end else if (w_in_run) begin
            if (eng_done) begin
                r_timeout <= 1'b0;
            end else if (w_expired) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign out_timeout = r_timeout;
`else
    assign w_expired   = 1'b0;
    assign out_timeout = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (input_stb)                  w_state_nxt = ST_HOLD;
            ST_HOLD:   if (r_hold_cnt == c_hold_last)  w_state_nxt = ST_RUN;
            ST_RUN:    if (eng_done || w_expired)      w_state_nxt = ST_RESULT;
            ST_RESULT: if (output_z_ack)               w_state_nxt = ST_IDLE;
            default:                                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_s1       <= '0;
            r_s2       <= '0;
            r_contact  <= CONTACT_ZERO;
            r_ret      <= 1'b0;
            r_out_stb  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == ST_HOLD) begin
                r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
            end else begin
                r_hold_cnt <= '0;
            end

            if (r_state == ST_IDLE && input_stb) begin
                r_s1 <= '{in_x1, in_y1, in_z1, in_r1};
                r_s2 <= '{in_x2, in_y2, in_z2, in_r2};
            end

            if (w_in_run) begin
                if (eng_done) begin
                    r_contact <= '{eng_cx, eng_cy, eng_cz, eng_nx, eng_ny,
                                   eng_nz, eng_depth};
                    r_ret     <= eng_ret;
                    r_out_stb <= 1'b1;
                end else if (w_expired) begin
                    r_contact <= CONTACT_ZERO;
                    r_ret     <= 1'b0;
                    r_out_stb <= 1'b1;
                end
            end

            if (r_state == ST_RESULT && output_z_ack) begin
                r_out_stb <= 1'b0;
            end
        end
    end

    // Gated with rst so a request is never acknowledged on the very edge
    // that the reset discards it.
    assign input_ack    = (r_state == ST_IDLE) && input_stb && rst;
    assign eng_rst      = w_in_run;
    assign output_z_stb = r_out_stb;

    assign eng_x1    = r_s1.x;
    assign eng_y1    = r_s1.y;
    assign eng_z1    = r_s1.z;
    assign eng_r1    = r_s1.r;
    assign eng_x2    = r_s2.x;
    assign eng_y2    = r_s2.y;
    assign eng_z2    = r_s2.z;
    assign eng_r2    = r_s2.r;

    assign out_cx    = r_contact.cx;
    assign out_cy    = r_contact.cy;
    assign out_cz    = r_contact.cz;
    assign out_nx    = r_contact.nx;
    assign out_ny    = r_contact.ny;
    assign out_nz    = r_contact.nz;
    assign out_depth = r_contact.depth;
    assign out_ret   = r_ret;

endmodule
`default_nettype wire

// File: tb/tb_sphere_pair_dispatcher.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sphere_pair_dispatcher
// Description : Self-checking bench for sphere_pair_dispatcher. A behavioural
//               engine/handshake model tracks the expected outputs each
//               cycle; directed cases pin hold length, latency, timeout and
//               reset-abort behaviour, then randomised transactions follow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sphere_pair_dispatcher;
    localparam int HOLD = 2;
    localparam int TMO  = 16;
`ifdef DISPATCH_TIMEOUT_EN
    localparam int D35  = 10;
`else
    localparam int D35  = 40;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_ops [8];
    logic [31:0] in_x1, in_y1, in_z1, in_r1, in_x2, in_y2, in_z2, in_r2;
    logic        input_stb = 1'b0;
    logic        input_ack;
    logic [31:0] eng_x1, eng_y1, eng_z1, eng_r1, eng_x2, eng_y2, eng_z2, eng_r2;
    logic        eng_rst;
    logic        eng_done = 1'b0;
    logic        eng_ret  = 1'b0;
    logic [31:0] eres [7];
    logic [31:0] eng_cx, eng_cy, eng_cz, eng_nx, eng_ny, eng_nz, eng_depth;
    logic [31:0] out_cx, out_cy, out_cz, out_nx, out_ny, out_nz, out_depth;
    logic        out_ret, out_timeout, output_z_stb;
    logic        output_z_ack = 1'b0;

    assign in_x1 = in_ops[0]; assign in_y1 = in_ops[1];
    assign in_z1 = in_ops[2]; assign in_r1 = in_ops[3];
    assign in_x2 = in_ops[4]; assign in_y2 = in_ops[5];
    assign in_z2 = in_ops[6]; assign in_r2 = in_ops[7];
    assign eng_cx = eres[0]; assign eng_cy = eres[1]; assign eng_cz = eres[2];
    assign eng_nx = eres[3]; assign eng_ny = eres[4]; assign eng_nz = eres[5];
    assign eng_depth = eres[6];

    sphere_pair_dispatcher #(
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_x1(in_x1), .in_y1(in_y1), .in_z1(in_z1), .in_r1(in_r1),
        .in_x2(in_x2), .in_y2(in_y2), .in_z2(in_z2), .in_r2(in_r2),
        .input_stb(input_stb), .input_ack(input_ack),
        .eng_x1(eng_x1), .eng_y1(eng_y1), .eng_z1(eng_z1), .eng_r1(eng_r1),
        .eng_x2(eng_x2), .eng_y2(eng_y2), .eng_z2(eng_z2), .eng_r2(eng_r2),
        .eng_rst(eng_rst), .eng_done(eng_done), .eng_ret(eng_ret),
        .eng_cx(eng_cx), .eng_cy(eng_cy), .eng_cz(eng_cz),
        .eng_nx(eng_nx), .eng_ny(eng_ny), .eng_nz(eng_nz), .eng_depth(eng_depth),
        .out_cx(out_cx), .out_cy(out_cy), .out_cz(out_cz),
        .out_nx(out_nx), .out_ny(out_ny), .out_nz(out_nz), .out_depth(out_depth),
        .out_ret(out_ret), .out_timeout(out_timeout),
        .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp_v);
        end
    endtask

    // Engine behaviour selected by the stimulus: 0 random results,
    // 1 ret=1 with depth 1.0 and other fields zero, 2 ret=0 with zero data.
    int cfg_mode  = 0;
    int cfg_delay = 10;
    int ack_mode  = 2;   // 0 random, 1 hold low, 2 hold high

    // Transaction-level model state.
    bit          busy = 1'b0;
    bit          res_valid = 1'b0;
    int          ack_cyc = 0;
    int          run_cnt = 0;
    logic [31:0] m_ops [8];
    logic [31:0] m_res [7];
    logic        m_ret = 1'b0;
    logic        m_to  = 1'b0;
    bit          running, exp_ack, done_now;
    logic [31:0] a_eng [8];
    logic [31:0] a_out [7];

    // Timestamps and counts observed on the DUT pins.
    int t_ack = 0, t_rise = 0, t_stb = 0, t_done = 0, n_ack = 0, n_stb_rise = 0;
    bit prev_erst = 1'b0, prev_stb = 1'b0;

    initial begin
        for (int i = 0; i < 8; i++) begin m_ops[i] = '0; in_ops[i] = '0; end
        for (int i = 0; i < 7; i++) begin m_res[i] = '0; eres[i] = '0; end
    end

    always @(posedge clk) begin
        #1;
        case (ack_mode)
            0:       output_z_ack = 1'($urandom_range(0, 1));
            1:       output_z_ack = 1'b0;
            default: output_z_ack = 1'b1;
        endcase
    end

    // Compare process plus engine model.
    always @(negedge clk) begin
        cyc++;
        // The engine is running once HOLD cycles have elapsed after the
        // accepting cycle and until a result has been produced.
        running = busy && !res_valid && ((cyc - ack_cyc) > HOLD);
        exp_ack = input_stb && !busy && (rst == 1'b1);
        a_eng = '{eng_x1, eng_y1, eng_z1, eng_r1, eng_x2, eng_y2, eng_z2, eng_r2};
        a_out = '{out_cx, out_cy, out_cz, out_nx, out_ny, out_nz, out_depth};
        if (chk_on) begin
            chk("input_ack", {31'd0, input_ack}, {31'd0, exp_ack});
            chk("eng_rst", {31'd0, eng_rst}, {31'd0, running});
            chk("output_z_stb", {31'd0, output_z_stb}, {31'd0, res_valid});
            for (int i = 0; i < 8; i++) chk($sformatf("eng_op%0d", i), a_eng[i], m_ops[i]);
            for (int i = 0; i < 7; i++) chk($sformatf("out_res%0d", i), a_out[i], m_res[i]);
            chk("out_ret", {31'd0, out_ret}, {31'd0, m_ret});
            chk("out_timeout", {31'd0, out_timeout}, {31'd0, m_to});
        end

        if (input_ack === 1'b1) begin t_ack = cyc; n_ack++; end
        if (eng_rst === 1'b1 && !prev_erst) t_rise = cyc;
        if (output_z_stb === 1'b1 && !prev_stb) begin t_stb = cyc; n_stb_rise++; end
        prev_erst = (eng_rst === 1'b1);
        prev_stb  = (output_z_stb === 1'b1);

        if (rst !== 1'b1) begin
            busy = 1'b0; res_valid = 1'b0; run_cnt = 0;
            m_ret = 1'b0; m_to = 1'b0; eng_done = 1'b0;
            for (int i = 0; i < 8; i++) m_ops[i] = '0;
            for (int i = 0; i < 7; i++) m_res[i] = '0;
        end else begin
            if (res_valid && output_z_ack) begin
                res_valid = 1'b0;
                busy      = 1'b0;
            end else if (exp_ack) begin
                busy    = 1'b1;
                ack_cyc = cyc;
                run_cnt = 0;
                for (int i = 0; i < 8; i++) m_ops[i] = in_ops[i];
            end

            for (int i = 0; i < 7; i++)
                eres[i] = (cfg_mode == 0) ? $urandom :
                          (cfg_mode == 1 && i == 6) ? 32'h3F80_0000 : 32'h0;
            eng_ret = (cfg_mode == 0) ? 1'($urandom_range(0, 1)) : (cfg_mode == 1);

            if (running) begin
                run_cnt++;
                done_now = (run_cnt == cfg_delay);
                eng_done = done_now;
                if (done_now) begin
                    for (int i = 0; i < 7; i++) m_res[i] = eres[i];
                    m_ret = eng_ret; m_to = 1'b0; res_valid = 1'b1; t_done = cyc;
                end
`ifdef DISPATCH_TIMEOUT_EN
                else if (run_cnt == TMO) begin
                    for (int i = 0; i < 7; i++) m_res[i] = '0;
                    m_ret = 1'b0; m_to = 1'b1; res_valid = 1'b1;
                end
`endif
            end else begin
                // Spurious completions outside RUN must be ignored.
                eng_done = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] req_ops [8];
    logic [31:0] cap_depth;
    logic        cap_ret, cap_to;

    task automatic request();
        bit got = 1'b0;
        for (int i = 0; i < 8; i++) in_ops[i] = req_ops[i];
        input_stb = 1'b1;
        for (int k = 0; k < 500 && !got; k++) begin
            @(negedge clk);
            if (input_ack === 1'b1) got = 1'b1;
        end
        if (!got) chk("request_ack_wait", 32'd0, 32'd1);
        @(posedge clk); #1;
        input_stb = 1'b0;
    endtask

    task automatic wait_result();
        bit seen = 1'b0, got = 1'b0;
        cap_depth = 'x; cap_ret = 'x; cap_to = 'x;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge clk);
            if (output_z_stb === 1'b1 && !seen) begin
                seen = 1'b1; cap_depth = out_depth; cap_ret = out_ret; cap_to = out_timeout;
            end
            if (output_z_stb === 1'b1 && output_z_ack === 1'b1) got = 1'b1;
        end
        if (!got) chk("result_wait", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic set_ops(input logic [31:0] a, b, c, d, e, f, g, h);
        req_ops[0] = a; req_ops[1] = b; req_ops[2] = c; req_ops[3] = d;
        req_ops[4] = e; req_ops[5] = f; req_ops[6] = g; req_ops[7] = h;
    endtask

    initial begin
        int base;
        bit got;
        rst = 1'b0;
        @(posedge clk); #1;
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stb", {31'd0, output_z_stb}, 32'd0);
        chk("reset_eng_rst", {31'd0, eng_rst}, 32'd0);
        chk("reset_out_depth", out_depth, 32'd0);
        chk("reset_eng_x1", eng_x1, 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Unit-sphere pair touching at x=1.0, collision with depth 1.0.
        cfg_mode = 1; cfg_delay = D35; ack_mode = 2; n_ack = 0;
        set_ops(32'h0, 32'h0, 32'h0, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 32'h0, 32'h3F80_0000);
        request();
        wait_result();
        chk("d35_ack_pulses", n_ack, 32'd1);
        chk("d35_hold_low", t_rise - t_ack - 1, HOLD);
        chk("d35_stb_latency", t_stb - t_done, 32'd1);
        chk("d35_run_len", t_stb - t_rise, D35);
        chk("d35_depth", cap_depth, 32'h3F80_0000);
        chk("d35_ret", {31'd0, cap_ret}, 32'd1);
        chk("d35_timeout", {31'd0, cap_to}, 32'd0);

        // Consumer stalls; a second request must wait for the handshake.
        cfg_mode = 0; cfg_delay = 5; ack_mode = 1;
        set_ops(32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88);
        request();
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(posedge clk); #1;
            if (output_z_stb === 1'b1) got = 1'b1;
        end
        if (!got) chk("d36_stb_wait", 32'd0, 32'd1);
        set_ops(32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7, 32'hA8);
        for (int i = 0; i < 8; i++) in_ops[i] = req_ops[i];
        input_stb = 1'b1; n_ack = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("d36_no_ack_while_held", n_ack, 32'd0);
        chk("d36_stb_held", {31'd0, output_z_stb}, 32'd1);
        ack_mode = 2;
        request();
        chk("d36_second_eng_x1", eng_x1, 32'hA1);
        wait_result();

        // Miss: engine reports no collision and zero data.
        cfg_mode = 2; cfg_delay = 7;
        set_ops(32'h0, 32'h0, 32'h0, 32'h3F00_0000, 32'h4120_0000, 32'h0, 32'h0, 32'h3F00_0000);
        request();
        wait_result();
        chk("d37_ret", {31'd0, cap_ret}, 32'd0);
        chk("d37_depth", cap_depth, 32'd0);

`ifdef DISPATCH_TIMEOUT_EN
        cfg_mode = 1; cfg_delay = 1000;
        request();
        wait_result();
        chk("d38_expiry_time", t_stb - t_rise, TMO);
        chk("d38_timeout", {31'd0, cap_to}, 32'd1);
        chk("d38_ret", {31'd0, cap_ret}, 32'd0);
        cfg_delay = TMO;
        request();
        wait_result();
        chk("d38_done_wins_to", {31'd0, cap_to}, 32'd0);
        chk("d38_done_wins_ret", {31'd0, cap_ret}, 32'd1);
`endif

        // Reset during RUN aborts the transfer.
        cfg_mode = 0; cfg_delay = 12;
        set_ops(32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8);
        request();
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(posedge clk); #1;
            if (eng_rst === 1'b1) got = 1'b1;
        end
        if (!got) chk("d39_run_wait", 32'd0, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        base = n_stb_rise;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("d39_eng_rst", {31'd0, eng_rst}, 32'd0);
        chk("d39_eng_x1", eng_x1, 32'd0);
        repeat (30) @(posedge clk);
        #1;
        chk("d39_no_stb", n_stb_rise - base, 32'd0);

        // Back-to-back requests with the consumer always ready.
        ack_mode = 2; cfg_delay = 4;
        set_ops(32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6, 32'hB7, 32'hB8);
        request();
        set_ops(32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5, 32'hC6, 32'hC7, 32'hC8);
        request();
        chk("d40_second_eng_r2", eng_r2, 32'hC8);
        wait_result();

        // Randomised transactions.
        ack_mode = 0;
        for (int n = 0; n < 25; n++) begin
            cfg_mode  = $urandom_range(0, 2);
            cfg_delay = $urandom_range(1, 24);
            for (int i = 0; i < 8; i++) req_ops[i] = $urandom;
            request();
            wait_result();
        end

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
